// File: rtl/axi_slave_mem.sv
// AXI4 slave memory with FIXED/INCR/WRAP bursts, byte strobes and per-beat SLVERR.
// Write and read channels are independent, each with one transaction in flight.
module axi_slave_mem #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int ID_W      = 4,
   parameter int MEM_DEPTH = 256
) (
   input  logic                aclk,
   input  logic                arst,
   input  logic [ID_W-1:0]     awid,
   input  logic [ADDR_W-1:0]   awaddr,
   input  logic [7:0]          awlen,
   input  logic [2:0]          awsize,
   input  logic [1:0]          awburst,
   input  logic                awvalid,
   output logic                awready,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic                wlast,
   input  logic                wvalid,
   output logic                wready,
   output logic [ID_W-1:0]     bid,
   output logic [1:0]          bresp,
   output logic                bvalid,
   input  logic                bready,
   input  logic [ID_W-1:0]     arid,
   input  logic [ADDR_W-1:0]   araddr,
   input  logic [7:0]          arlen,
   input  logic [2:0]          arsize,
   input  logic [1:0]          arburst,
   input  logic                arvalid,
   output logic                arready,
   output logic [ID_W-1:0]     rid,
   output logic [DATA_W-1:0]   rdata,
   output logic [1:0]          rresp,
   output logic                rlast,
   output logic                rvalid,
   input  logic                rready
);
   localparam int STRB_W = DATA_W / 8;
   localparam int OFF    = $clog2(STRB_W);
   localparam int IDX_W  = $clog2(MEM_DEPTH);
   localparam logic [2:0] MAX_SIZE = 3'(OFF);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic       {R_IDLE, R_DATA} rstate_t;

   logic [DATA_W-1:0] r_mem [MEM_DEPTH];

   function automatic logic txn_bad(input logic [7:0] len, input logic [2:0] size,
                                    input logic [1:0] burst);
      logic w_wrap_ok;
      w_wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      return (burst == 2'b11) || ((burst == 2'b10) && !w_wrap_ok) || (size > MAX_SIZE);
   endfunction

   function automatic logic addr_oob(input logic [ADDR_W-1:0] a);
      return (a >> OFF) >= ADDR_W'(MEM_DEPTH);
   endfunction

   // WRAP keeps the bits above the wrap window and increments only inside it
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [7:0] len,
                                                   input logic [2:0] size,
                                                   input logic [1:0] burst);
      logic [ADDR_W-1:0] w_sum, w_mask;
      w_sum  = a + (ADDR_W'(1) << size);
      w_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
      case (burst)
         2'b00:   return a;
         2'b10:   return (a & ~w_mask) | (w_sum & w_mask);
         default: return w_sum;
      endcase
   endfunction

   // ---------------- write channel ----------------
   wstate_t           r_wstate, w_wstate_nxt;
   logic [ID_W-1:0]   r_wid;
   logic [ADDR_W-1:0] r_waddr;
   logic [7:0]        r_wlen, r_wbeat;
   logic [2:0]        r_wsize;
   logic [1:0]        r_wburst;
   logic              r_wpast, r_werr;
   logic              w_aw_hs, w_w_hs, w_wbeat_err, w_wen;
   logic [IDX_W-1:0]  w_widx;

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) r_wstate <= W_IDLE;
      else      r_wstate <= w_wstate_nxt;
   end

   always_comb begin
      w_wstate_nxt = r_wstate;
      awready      = 1'b0;
      wready       = 1'b0;
      bvalid       = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            awready = 1'b1;
            if (awvalid) w_wstate_nxt = W_DATA;
         end
         W_DATA: begin
            wready = 1'b1;
            if (wvalid && wlast) w_wstate_nxt = W_RESP;
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (bready) w_wstate_nxt = W_IDLE;
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   assign w_aw_hs     = (r_wstate == W_IDLE) && awvalid;
   assign w_w_hs      = (r_wstate == W_DATA) && wvalid;
   assign w_wbeat_err = txn_bad(r_wlen, r_wsize, r_wburst) || addr_oob(r_waddr) || r_wpast ||
                        (wlast != (r_wbeat == r_wlen));
   assign w_wen       = w_w_hs && !w_wbeat_err;
   assign w_widx      = r_waddr[OFF +: IDX_W];
   assign bid         = r_wid;
   assign bresp       = {r_werr, 1'b0};

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         r_wid    <= '0;
         r_waddr  <= '0;
         r_wlen   <= '0;
         r_wsize  <= '0;
         r_wburst <= '0;
         r_wbeat  <= '0;
         r_wpast  <= 1'b0;
         r_werr   <= 1'b0;
      end else begin
         if (w_aw_hs) begin
            r_wid    <= awid;
            r_waddr  <= awaddr;
            r_wlen   <= awlen;
            r_wsize  <= awsize;
            r_wburst <= awburst;
            r_wbeat  <= '0;
            r_wpast  <= 1'b0;
            r_werr   <= 1'b0;
         end
         if (w_w_hs) begin
            r_werr  <= r_werr | w_wbeat_err;
            r_waddr <= next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
            // beats beyond awlen are still accepted, and flagged as errors
            if (r_wbeat == r_wlen) r_wpast <= 1'b1;
            else if (!r_wpast)     r_wbeat <= r_wbeat + 8'd1;
         end
      end
   end

   always_ff @(posedge aclk) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
         if (w_wen && wstrb[b]) r_mem[w_widx][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   // ---------------- read channel ----------------
   rstate_t           r_rstate, w_rstate_nxt;
   logic [ID_W-1:0]   r_rid;
   logic [ADDR_W-1:0] r_raddr, w_rsel_addr;
   logic [7:0]        r_rlen, r_rbeat, w_rsel_len, w_rbeat_nxt;
   logic [2:0]        r_rsize, w_rsel_size;
   logic [1:0]        r_rburst, w_rsel_burst;
   logic [DATA_W-1:0] r_rdata;
   logic [1:0]        r_rresp;
   logic              r_rlast;
   logic              w_ar_hs, w_r_hs, w_rload, w_rsel_err;

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) r_rstate <= R_IDLE;
      else      r_rstate <= w_rstate_nxt;
   end

   always_comb begin
      w_rstate_nxt = r_rstate;
      arready      = 1'b0;
      rvalid       = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            arready = 1'b1;
            if (arvalid) w_rstate_nxt = R_DATA;
         end
         R_DATA: begin
            rvalid = 1'b1;
            if (rready && r_rlast) w_rstate_nxt = R_IDLE;
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   // beat to load: beat 0 straight from AR when idle, else the successor of the current beat
   always_comb begin
      if (r_rstate == R_IDLE) begin
         w_rsel_addr  = araddr;
         w_rsel_len   = arlen;
         w_rsel_size  = arsize;
         w_rsel_burst = arburst;
      end else begin
         w_rsel_addr  = next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
         w_rsel_len   = r_rlen;
         w_rsel_size  = r_rsize;
         w_rsel_burst = r_rburst;
      end
   end

   assign w_ar_hs     = (r_rstate == R_IDLE) && arvalid;
   assign w_r_hs      = (r_rstate == R_DATA) && rready;
   assign w_rload     = w_ar_hs || (w_r_hs && !r_rlast);
   assign w_rsel_err  = txn_bad(w_rsel_len, w_rsel_size, w_rsel_burst) || addr_oob(w_rsel_addr);
   assign w_rbeat_nxt = r_rbeat + 8'd1;
   assign rid         = r_rid;
   assign rdata       = r_rdata;
   assign rresp       = r_rresp;
   assign rlast       = r_rlast;

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         r_rid    <= '0;
         r_raddr  <= '0;
         r_rlen   <= '0;
         r_rsize  <= '0;
         r_rburst <= '0;
         r_rbeat  <= '0;
         r_rdata  <= '0;
         r_rresp  <= '0;
         r_rlast  <= 1'b0;
      end else begin
         if (w_ar_hs) begin
            r_rid    <= arid;
            r_rlen   <= arlen;
            r_rsize  <= arsize;
            r_rburst <= arburst;
            r_rbeat  <= '0;
         end else if (w_rload) begin
            r_rbeat  <= w_rbeat_nxt;
         end
         if (w_rload) begin
            r_raddr <= w_rsel_addr;
            r_rdata <= w_rsel_err ? '0 : r_mem[w_rsel_addr[OFF +: IDX_W]];
            r_rresp <= {w_rsel_err, 1'b0};
            r_rlast <= w_ar_hs ? (arlen == 8'd0) : (w_rbeat_nxt == r_rlen);
         end else if (w_r_hs && r_rlast) begin
            r_rlast <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomised bench for axi_slave_mem against a transaction-level memory model.
// A single negedge process scores every R and B handshake against queued expectations.
module tb_axi_slave_mem;
   localparam int DEPTH = 256;

   logic        aclk = 1'b0, arst = 1'b1;
   logic [3:0]  awid = '0, arid = '0, bid, rid;
   logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
   logic [7:0]  awlen = '0, arlen = '0;
   logic [2:0]  awsize = '0, arsize = '0;
   logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
   logic [3:0]  wstrb = '0;
   logic        awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
   logic        awready, wready, bvalid, arready, rvalid, rlast;

   axi_slave_mem #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .MEM_DEPTH(DEPTH)) dut (
      .aclk(aclk), .arst(arst),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   always #5 aclk = ~aclk;

   int checks = 0, failures = 0;

   typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
   typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

   logic [31:0] mdl_mem [DEPTH];
   rbeat_t      exp_r[$];
   bexp_t       exp_b[$];
   logic [31:0] got_r[$];
   logic [1:0]  got_rresp[$];
   logic [1:0]  last_bresp;
   logic [31:0] wq_data[$];
   logic [3:0]  wq_strb[$];

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int i);
      longint unsigned inc, wb, lower, ofs;
      inc = 64'd1 << size;
      if (burst == 2'd0) return a;
      if (burst == 2'd2) begin
         wb    = (longint'(len) + 1) * inc;
         lower = a - (a % wb);
         ofs   = (a - lower + longint'(i) * inc) % wb;
         return 32'(lower + ofs);
      end
      return 32'(a + longint'(i) * inc);
   endfunction

   function automatic bit txn_illegal(input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
      return burst == 2'd3 || (burst == 2'd2 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
             size > 3'd2;
   endfunction

   function automatic bit beat_oob(input logic [31:0] a);
      return (a >> 2) >= DEPTH;
   endfunction

   // ---------------- scoreboard ----------------
   bit          prev_stall = 0;
   logic [31:0] prev_rdata;
   logic [1:0]  prev_rresp;
   logic        prev_rlast;

   always @(negedge aclk) begin
      rbeat_t e;
      bexp_t  be;
      if (arst) begin
         prev_stall = 0;
      end else begin
         if (prev_stall && rvalid) begin
            check("r_hold_data", rdata, prev_rdata);
            check("r_hold_resp", rresp, prev_rresp);
            check("r_hold_last", rlast, prev_rlast);
         end
         prev_stall = rvalid && !rready;
         prev_rdata = rdata;
         prev_rresp = rresp;
         prev_rlast = rlast;
         if (rvalid && rready) begin
            if (exp_r.size() == 0) begin
               checks++; failures++;
               $display("FAIL r_unexpected got rdata=%0h want no beat", rdata);
            end else begin
               e = exp_r.pop_front();
               check("rid", rid, e.id);
               check("rdata", rdata, e.data);
               check("rresp", rresp, e.resp);
               check("rlast", rlast, e.last);
            end
            got_r.push_back(rdata);
            got_rresp.push_back(rresp);
         end
         if (bvalid && bready) begin
            if (exp_b.size() == 0) begin
               checks++; failures++;
               $display("FAIL b_unexpected got bresp=%0h want no response", bresp);
            end else begin
               be = exp_b.pop_front();
               check("bid", bid, be.id);
               check("bresp", bresp, be.resp);
            end
            last_bresp = bresp;
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic fill_rand(input int n, input bit full_strb);
      wq_data.delete(); wq_strb.delete();
      for (int i = 0; i < n; i++) begin
         wq_data.push_back($urandom);
         wq_strb.push_back(full_strb ? 4'hF : 4'($urandom));
      end
   endtask

   task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int wlast_at, input int bstall);
      bit ill, err, berr;
      logic [31:0] a;
      int cyc;
      ill = txn_illegal(len, size, burst);
      err = 0;
      for (int i = 0; i <= wlast_at; i++) begin
         a    = beat_addr(addr, len, size, burst, i);
         berr = ill || i > int'(len) || ((i == wlast_at) != (i == int'(len))) || beat_oob(a);
         if (!berr)
            for (int b = 0; b < 4; b++)
               if (wq_strb[i][b]) mdl_mem[a >> 2][8*b +: 8] = wq_data[i][8*b +: 8];
         err |= berr;
      end
      exp_b.push_back('{id: id, resp: err ? 2'b10 : 2'b00});

      @(posedge aclk); #1;
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1;
      cyc = 0;
      @(negedge aclk);
      while (!awready && cyc < 50) begin @(negedge aclk); cyc++; end
      if (cyc >= 50) check("aw_timeout", 0, 1);
      @(posedge aclk); #1;
      awvalid = 0;
      check("aw_busy", awready, 0);
      check("w_ready_after_aw", wready, 1);
      for (int i = 0; i <= wlast_at; i++) begin
         if ($urandom_range(3) == 0) begin
            wvalid = 0;
            @(posedge aclk); #1;
         end
         wvalid = 1; wdata = wq_data[i]; wstrb = wq_strb[i]; wlast = (i == wlast_at);
         @(negedge aclk);
         check("w_ready", wready, 1);
         @(posedge aclk); #1;
      end
      wvalid = 0; wlast = 0;
      check("b_latency", bvalid, 1);
      check("w_ready_after_last", wready, 0);
      bready = 0;
      for (int k = 0; k < bstall; k++) begin
         @(negedge aclk);
         check("b_hold", bvalid, 1);
         check("aw_blocked", awready, 0);
         @(posedge aclk); #1;
      end
      bready = 1;
      cyc = 0;
      @(negedge aclk);
      while (!bvalid && cyc < 50) begin @(negedge aclk); cyc++; end
      if (cyc >= 50) check("b_timeout", 0, 1);
      @(posedge aclk); #1;
      bready = 0;
      check("aw_ready_after_b", awready, 1);
   endtask

   task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int stall_pct, input int max_beats);
      bit ill, err;
      logic [31:0] a;
      int n, cyc, total;
      ill = txn_illegal(len, size, burst);
      total = int'(len) + 1;
      for (int i = 0; i < total; i++) begin
         a   = beat_addr(addr, len, size, burst, i);
         err = ill || beat_oob(a);
         exp_r.push_back('{id: id, data: err ? 32'h0 : mdl_mem[(a >> 2) % DEPTH],
                           resp: err ? 2'b10 : 2'b00, last: (i == total - 1)});
      end
      got_r.delete(); got_rresp.delete();

      @(posedge aclk); #1;
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1;
      cyc = 0;
      @(negedge aclk);
      while (!arready && cyc < 50) begin @(negedge aclk); cyc++; end
      if (cyc >= 50) check("ar_timeout", 0, 1);
      @(posedge aclk); #1;
      arvalid = 0;
      check("r_valid_after_ar", rvalid, 1);
      check("ar_busy", arready, 0);
      n = 0; cyc = 0;
      while (n < total && (max_beats < 0 || n < max_beats) && cyc < 2000) begin
         rready = ($urandom_range(99) >= stall_pct);
         @(negedge aclk);
         if (rvalid && rready) n++;
         @(posedge aclk); #1;
         cyc++;
      end
      rready = 0;
      if (cyc >= 2000) check("r_timeout", n, total);
      if (max_beats < 0) begin
         check("r_all_consumed", exp_r.size(), 0);
         check("ar_ready_after_last", arready, 1);
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      int          wlast_at, r;
      int          wrap_exp[4] = '{14, 15, 12, 13};
      logic [31:0] wd[4];

      repeat (2) @(negedge aclk);
      check("rst_awready", awready, 1);
      check("rst_arready", arready, 1);
      check("rst_wready", wready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rlast", rlast, 0);
      check("rst_bid", bid, 0);
      check("rst_bresp", bresp, 0);
      check("rst_rid", rid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_rresp", rresp, 0);
      @(posedge aclk); #1 arst = 0;

      fill_rand(256, 1);
      axi_write(4'd0, 32'h0, 8'd255, 3'd2, 2'd1, 255, 0);

      wq_data = '{32'd1, 32'd2, 32'd3, 32'd4};
      wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
      axi_write(4'd5, 32'h10, 8'd3, 3'd2, 2'd1, 3, 0);
      check("incr_bresp_lit", last_bresp, 2'b00);
      axi_read(4'd6, 32'h10, 8'd3, 3'd2, 2'd1, 0, -1);
      for (int i = 0; i < 4; i++) check("incr_rdata_lit", got_r[i], i + 1);

      for (int i = 0; i < 4; i++)
         check("wrap_word_lit", beat_addr(32'h38, 8'd3, 3'd2, 2'd2, i) >> 2, wrap_exp[i]);
      fill_rand(4, 1);
      for (int i = 0; i < 4; i++) wd[i] = wq_data[i];
      axi_write(4'd7, 32'h38, 8'd3, 3'd2, 2'd2, 3, 0);
      axi_read(4'd8, 32'h38, 8'd3, 3'd2, 2'd2, 30, -1);
      axi_read(4'd8, 32'h30, 8'd3, 3'd2, 2'd1, 0, -1);
      check("wrap_w12_lit", got_r[0], wd[2]);
      check("wrap_w13_lit", got_r[1], wd[3]);
      check("wrap_w14_lit", got_r[2], wd[0]);
      check("wrap_w15_lit", got_r[3], wd[1]);

      wq_data = '{32'h11223344}; wq_strb = '{4'hF};
      axi_write(4'd1, 32'h80, 8'd0, 3'd2, 2'd1, 0, 0);
      wq_data = '{32'hAABBCCDD}; wq_strb = '{4'b0101};
      axi_write(4'd1, 32'h80, 8'd0, 3'd2, 2'd1, 0, 0);
      axi_read(4'd2, 32'h80, 8'd0, 3'd2, 2'd1, 0, -1);
      check("strobe_lit", got_r[0], 32'h11BB33DD);

      wq_data = '{32'hDEADBEEF}; wq_strb = '{4'hF};
      axi_write(4'd3, 32'h80, 8'd0, 3'd2, 2'd3, 0, 0);
      check("burst3_bresp_lit", last_bresp, 2'b10);
      axi_read(4'd3, 32'h80, 8'd0, 3'd2, 2'd1, 0, -1);
      check("burst3_mem_lit", got_r[0], 32'h11BB33DD);

      axi_read(4'd4, 32'h400, 8'd0, 3'd2, 2'd1, 0, -1);
      check("oob_rdata_lit", got_r[0], 0);
      check("oob_rresp_lit", got_rresp[0], 2'b10);

      fill_rand(3, 1);
      axi_write(4'd9, 32'h40, 8'd2, 3'd2, 2'd2, 2, 0);
      check("wrap_len2_lit", last_bresp, 2'b10);
      axi_read(4'd9, 32'h40, 8'd2, 3'd2, 2'd2, 0, -1);

      fill_rand(2, 1);
      axi_write(4'd10, 32'h60, 8'd1, 3'd2, 2'd1, 1, 5);
      axi_read(4'd11, 32'h0, 8'd15, 3'd2, 2'd1, 50, -1);

      fill_rand(2, 1);
      axi_write(4'd12, 32'h90, 8'd3, 3'd2, 2'd1, 1, 0);
      check("wlast_early_lit", last_bresp, 2'b10);
      fill_rand(4, 1);
      axi_write(4'd12, 32'hA0, 8'd1, 3'd2, 2'd1, 3, 1);
      check("wlast_late_lit", last_bresp, 2'b10);
      axi_read(4'd13, 32'h90, 8'd7, 3'd2, 2'd1, 20, -1);

      fill_rand(4, 1);
      axi_write(4'd14, 32'h100, 8'd3, 3'd2, 2'd1, 3, 0);
      axi_read(4'd14, 32'h100, 8'd3, 3'd2, 2'd1, 0, 2);
      arst = 1;
      #1;
      check("midrst_rvalid", rvalid, 0);
      check("midrst_arready", arready, 1);
      check("midrst_awready", awready, 1);
      check("midrst_rdata", rdata, 0);
      check("midrst_rlast", rlast, 0);
      exp_r.delete();
      @(posedge aclk); #1 arst = 0;
      axi_read(4'd15, 32'h100, 8'd3, 3'd2, 2'd1, 0, -1);

      for (int t = 0; t < 40; t++) begin
         id    = 4'($urandom);
         burst = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
         size  = ($urandom_range(9) == 0) ? 3'd3 : 3'($urandom_range(2));
         if (burst == 2'd2) begin
            case ($urandom_range(4))
               0: len = 8'd1;
               1: len = 8'd3;
               2: len = 8'd7;
               3: len = 8'd15;
               default: len = 8'd2;
            endcase
         end else begin
            len = 8'($urandom_range(7));
         end
         addr = $urandom_range(32'h43F);
         if ($urandom_range(1) == 1) begin
            wlast_at = int'(len);
            r = $urandom_range(7);
            if (r == 0) wlast_at = int'(len) + 1;
            else if (r == 1 && len > 0) wlast_at = int'(len) - 1;
            fill_rand(wlast_at + 1, 0);
            axi_write(id, addr, len, size, burst, wlast_at, $urandom_range(3));
         end else begin
            axi_read(id, addr, len, size, burst, $urandom_range(60), -1);
         end
      end
      for (int t = 0; t < 4; t++)
         axi_read(4'd0, 32'(t * 256), 8'd63, 3'd2, 2'd1, 10, -1);

      check("b_all_consumed", exp_b.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog got=timeout want=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule
